// File: rtl/o_serdes_tx.sv
// LSB-first serializer of WIDTH-bit words with per-word output enable; D[0] on Q the edge after accept.
// DATA_READY opens in IDLE and on the last bit, so words stream gap-free; a missed boundary pulses UNDERRUN.
module o_serdes_tx #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_VALUE = 1'b0,
  parameter logic IDLE_OE    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  input  logic             OE_IN,
  output logic             DATA_READY,
  output logic             Q,
  output logic             OE_OUT,
  output logic             UNDERRUN
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if ((WIDTH < 3) || (WIDTH > 10)) begin : g_bad_width
    $fatal(1, "%m: WIDTH=%0d outside legal range 3..10", WIDTH);
  end
  if ((IDLE_VALUE !== 1'b0 && IDLE_VALUE !== 1'b1) || (IDLE_OE !== 1'b0 && IDLE_OE !== 1'b1)) begin : g_bad_idle
    $fatal(1, "%m: IDLE_VALUE/IDLE_OE must be 1-bit 0 or 1");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oe_q, oe_d;
  logic             q_q, q_d;
  logic             oe_out_q, oe_out_d;
  logic             underrun_q, underrun_d;
  logic             accept;

  assign DATA_READY = RST & ((state_q == IDLE) | ((state_q == SHIFT) & (cnt_q == LAST)));
  assign accept     = DATA_VALID & DATA_READY;
  assign Q          = q_q;
  assign OE_OUT     = oe_out_q;
  assign UNDERRUN   = underrun_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      q_q        <= IDLE_VALUE;
      oe_out_q   <= IDLE_OE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      oe_q       <= oe_d;
      q_q        <= q_d;
      oe_out_q   <= oe_out_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    oe_d       = oe_q;
    q_d        = q_q;
    oe_out_d   = oe_out_q;
    underrun_d = 1'b0;
    if (accept) begin
      // A new word preempts the idle/underrun path, giving gap-free streaming.
      q_d      = D[0];
      oe_out_d = OE_IN;
      sr_d     = D >> 1;
      oe_d     = OE_IN;
      cnt_d    = '0;
      state_d  = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST) begin
            q_d      = sr_q[0];
            sr_d     = sr_q >> 1;
            oe_out_d = oe_q;
            cnt_d    = cnt_q + CW'(1);
          end else begin
            state_d    = IDLE;
            q_d        = IDLE_VALUE;
            oe_out_d   = IDLE_OE;
            underrun_d = 1'b1;
          end
        end
        default: begin
          q_d      = IDLE_VALUE;
          oe_out_d = IDLE_OE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_o_serdes_tx.sv
// Bench for o_serdes_tx: directed words on a WIDTH=4 and a WIDTH=10/IDLE_VALUE=1 instance,
// expected per-cycle outputs queued by cycle number and compared by a negedge monitor.
module tb_o_serdes_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] d4;
  logic       vld4, oe4, rdy4, q4, oeo4, un4;
  logic [9:0] d10;
  logic       vld10, oe10, rdy10, q10, oeo10, un10;

  o_serdes_tx #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RST(rst_n), .D(d4), .DATA_VALID(vld4), .OE_IN(oe4),
    .DATA_READY(rdy4), .Q(q4), .OE_OUT(oeo4), .UNDERRUN(un4)
  );

  o_serdes_tx #(.WIDTH(10), .IDLE_VALUE(1'b1), .IDLE_OE(1'b0)) u_dut10 (
    .CLK(clk), .RST(rst_n), .D(d10), .DATA_VALID(vld10), .OE_IN(oe10),
    .DATA_READY(rdy10), .Q(q10), .OE_OUT(oeo10), .UNDERRUN(un10)
  );

  typedef struct {
    int   cyc;
    int   sel;
    logic q;
    logic oe;
    logic un;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] outs(input int sel);
    if (sel != 0) return {q10, oeo10, un10, rdy10};
    return {q4, oeo4, un4, rdy4};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got q/oe/un/rdy=%b expected %b", name, act, exp);
    end
  endtask

  // Keep the queue sorted by cycle so both instances can be scored in the same window.
  task automatic push_one(input exp_t e);
    int idx;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic push_vec(input int base, input int sel, input int n,
                          input logic [15:0] qv, input logic [15:0] oev,
                          input logic [15:0] unv, input logic [15:0] rdyv);
    for (int i = 0; i < n; i++)
      push_one('{cyc: base + i, sel: sel, q: qv[i], oe: oev[i], un: unv[i], rdy: rdyv[i]});
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed cyc%0d dut%0d: sample never taken, now cyc%0d", mon_e.cyc, mon_e.sel, cyc);
    end
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check($sformatf("cyc%0d dut%0d", mon_e.cyc, mon_e.sel), outs(mon_e.sel),
            {mon_e.q, mon_e.oe, mon_e.un, mon_e.rdy});
    end
  end

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    d4 = '0; vld4 = 1'b0; oe4 = 1'b0;
    d10 = '0; vld10 = 1'b0; oe10 = 1'b0;
    rst_n = 1'b0;

    // Reset values, including the IDLE_VALUE=1 instance.
    repeat (3) slot();
    check("reset dut4", outs(0), 4'b0000);
    check("reset dut10", outs(1), 4'b1000);

    // Release and idle for 10 cycles.
    slot();
    rst_n = 1'b1;
    c = cyc;
    push_vec(c, 0, 10, 16'h0000, 16'h0000, 16'h0000, 16'h03FF);
    push_vec(c, 1, 10, 16'h03FF, 16'h0000, 16'h0000, 16'h03FF);
    repeat (10) slot();

    // Single word 1011 with OE=1, then underrun.
    c = cyc;
    d4 = 4'b1011; oe4 = 1'b1; vld4 = 1'b1;
    push_vec(c + 1, 0, 6, 16'h000B, 16'h000F, 16'h0010, 16'h0038);
    slot();
    vld4 = 1'b0;
    repeat (6) slot();

    // Back-to-back A then 5.
    c = cyc;
    d4 = 4'hA; oe4 = 1'b1; vld4 = 1'b1;
    push_vec(c + 1, 0, 10, 16'h005A, 16'h00FF, 16'h0100, 16'h0388);
    slot();
    d4 = 4'h5;
    repeat (4) slot();
    vld4 = 1'b0;
    repeat (6) slot();

    // OE per word with mid-word toggles that must be ignored.
    c = cyc;
    d4 = 4'hA; oe4 = 1'b1; vld4 = 1'b1;
    push_vec(c + 1, 0, 10, 16'h005A, 16'h000F, 16'h0100, 16'h0388);
    slot(); d4 = 4'h5; oe4 = 1'b0;
    slot(); oe4 = 1'b1;
    slot(); oe4 = 1'b0;
    slot();
    slot(); vld4 = 1'b0; oe4 = 1'b1;
    slot(); oe4 = 1'b0;
    slot(); oe4 = 1'b1;
    slot(); oe4 = 1'b0;
    repeat (4) slot();

    // Reset after two bits of 4'hF; no underrun afterwards.
    c = cyc;
    d4 = 4'hF; oe4 = 1'b1; vld4 = 1'b1;
    push_vec(c + 1, 0, 2, 16'h0003, 16'h0003, 16'h0000, 16'h0000);
    slot();
    vld4 = 1'b0;
    slot();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-word reset dut4", outs(0), 4'b0000);
    check("mid-word reset dut10", outs(1), 4'b1000);
    repeat (2) slot();
    rst_n = 1'b1;
    push_vec(cyc, 0, 6, 16'h0000, 16'h0000, 16'h0000, 16'h003F);
    repeat (6) slot();

    // WIDTH=10, IDLE_VALUE=1: ten 1s, idle high, one underrun pulse.
    c = cyc;
    d10 = 10'h3FF; oe10 = 1'b1; vld10 = 1'b1;
    push_vec(c + 1, 1, 12, 16'h0FFF, 16'h03FF, 16'h0400, 16'h0E00);
    slot();
    vld10 = 1'b0;
    repeat (13) slot();

    repeat (3) slot();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
